mux_n_a_1_arb: RTL and testbench
================================

MUX_N_A_1_ARB -- requirements
Module: mux_n_a_1_arb

Interface
REQ-001 The block SHALL have parameter ANCHO, default 8, giving the data width per channel.
REQ-002 The block SHALL have parameter CANALES, default 4, giving the number of input channels; legal range is 2..16, and non-power-of-2 values are supported.
REQ-003 The block SHALL have input clk_i, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have input rst_n_i, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have input modo_i, 1 bit: 0 selects fixed priority (lowest index wins), 1 selects round-robin.
REQ-006 The block SHALL have input valido_i, CANALES bits: per-channel request/valid.
REQ-007 The block SHALL have input entradas_i, CANALES*ANCHO bits: channel k data occupies bits [k*ANCHO +: ANCHO].
REQ-008 The block SHALL have output listo_o, CANALES bits: per-channel accept; at most one bit set.
REQ-009 The block SHALL have output salida_o, ANCHO bits: registered selected data.
REQ-010 The block SHALL have output valido_o, 1 bit: salida_o holds an unconsumed word.
REQ-011 The block SHALL have input listo_i, 1 bit: the downstream consumer accepts the word when valido_o and listo_i are both 1.
REQ-012 The block SHALL have output canal_o, $clog2(CANALES) bits: index of the channel that produced salida_o.

Function
REQ-013 Two-state FSM: VACIO (output register empty) and LLENO (output register holds a word).
- Transitions: VACIO->LLENO on any accepted input; LLENO->VACIO when the output is consumed and no input is accepted in the same cycle; otherwise the state holds.
REQ-014 Arbitration is enabled when state==VACIO, or when state==LLENO and listo_i==1.
REQ-015 When arbitration is enabled and valido_i!=0, exactly one listo_o bit SHALL be asserted in the same cycle, chosen per modo_i; otherwise listo_o SHALL be 0.
REQ-016 Fixed priority (modo_i=0): grant goes to the lowest index k with valido_i[k]=1.
REQ-017 Round-robin (modo_i=1): search starts at the pointer and wraps past CANALES-1 to 0; grant goes to the first requester found.
REQ-018 On a transfer from channel k, the pointer SHALL become (k+1) mod CANALES.
- The pointer updates only on a transfer, in either mode.
- A change of modo_i takes effect at the next arbitration; the pointer is retained across the change.
REQ-019 A transfer from channel k SHALL load salida_o=entradas_i[k], canal_o=k and valido_o=1 at the next clock edge (latency 1 cycle).
REQ-020 While valido_o=1 and listo_i=0, salida_o, canal_o and valido_o SHALL remain stable.
REQ-021 Simultaneous consume and accept SHALL replace the word in place, sustaining one word per cycle.
REQ-022 Consume with no accept SHALL clear valido_o; salida_o retains its last value.
REQ-023 listo_o depends combinationally on valido_i, state and listo_i only; it never depends on entradas_i.

Reset
REQ-024 While rst_n_i=0, the following SHALL hold, asynchronously: valido_o=0, salida_o=0, canal_o=0, pointer=0, state=VACIO.
REQ-025 Reset asserted mid-transfer SHALL discard the held word; listo_o=0 for the duration of reset.
REQ-026 Operation SHALL resume normally on the first rising edge after rst_n_i deasserts.

Structure
REQ-027 Package mux_pkg SHALL hold the estado_t enum (VACIO, LLENO) and the constants MODO_FIJO=1'b0 and MODO_RR=1'b1.
REQ-028 Arbitration SHALL live in sub-module arbitro_rr, which contains the grant logic and the pointer register and is parametrised by CANALES.

Verification
REQ-029 The bench SHALL cover these directed scenarios (CANALES=4, ANCHO=8):
- V1: reset; then valido_i=4'b0000 -> listo_o=0, valido_o=0, salida_o=0.
- V2: modo_i=0, valido_i=4'b1010, data ch1=8'h11, ch3=8'h33, listo_i=1 -> ch1 granted every cycle; salida_o=8'h11, canal_o=1; ch3 starved.
- V3: modo_i=1, valido_i=4'b1111 held, listo_i=1 -> canal_o sequence 0,1,2,3,0 on consecutive cycles; valido_o stays 1.
- V4: valido_o=1 holding 8'hA5 from ch2; listo_i=0 for 3 cycles with valido_i=4'b0001 -> listo_o=0, salida_o=8'hA5 stable; listo_i=1 -> ch0 accepted the same cycle, replacing the word the next cycle.
- V5: CANALES=3, modo_i=1, pointer at 2, valido_i=3'b011 -> grant ch0 (wrap), then ch1.
- V6: rst_n_i pulsed low mid-stream while valido_o=1 -> valido_o drops immediately; pointer=0; the next grant under round-robin goes to the lowest requester.

Source files
------------

// File: rtl/mux_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
// Shared definitions for the N-to-1 arbitrated multiplexer slice.
//   estado_t  : output-register occupancy state (VACIO / LLENO)
//   MODO_FIJO : modo_i value that selects fixed priority (lowest index wins)
//   MODO_RR   : modo_i value that selects round-robin
// -----------------------------------------------------------------------------
package mux_pkg;

    typedef enum logic {
        VACIO = 1'b0,   // output register empty
        LLENO = 1'b1    // output register holds an unconsumed word
    } estado_t;

    localparam logic MODO_FIJO = 1'b0;
    localparam logic MODO_RR   = 1'b1;

    // Index width for a given channel count; never below one bit.
    function automatic int ancho_indice(input int canales);
        return (canales > 1) ? $clog2(canales) : 1;
    endfunction

endpackage : mux_pkg

// File: rtl/mux_n_a_1_arb_arbitro_rr.sv
// -----------------------------------------------------------------------------
// arbitro_rr
// Grant logic plus round-robin pointer for the N-to-1 multiplexer.
//
// Ports
//   clk_i        : clock, rising edge
//   rst_n_i      : asynchronous active-low reset (clears the pointer)
//   modo_i       : MODO_FIJO = lowest index wins, MODO_RR = search from pointer
//   habilitado_i : arbitration allowed this cycle (the top owns this decision)
//   valido_i     : per-channel request
//   listo_o      : one-hot grant, all zero when disabled or nobody requests
//   canal_o      : index of the granted channel (meaningful when grant_o = 1)
//   grant_o      : a transfer happens this cycle
//
// Handshake: a channel transfers in a cycle where its valido_i and its
// listo_o bit are both 1; the grant is purely combinational.
// -----------------------------------------------------------------------------
module arbitro_rr
    import mux_pkg::*;
#(
    parameter int CANALES = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_n_i,
    input  logic                                modo_i,
    input  logic                                habilitado_i,
    input  logic [CANALES-1:0]                  valido_i,
    output logic [CANALES-1:0]                  listo_o,
    output logic [ancho_indice(CANALES)-1:0]    canal_o,
    output logic                                grant_o
);

    localparam int IW = ancho_indice(CANALES);

    logic [IW-1:0] puntero;
    logic [IW-1:0] indice;
    logic          hallado;
    int            j;

    // Walk the channels once. In round-robin the walk starts at the pointer
    // and wraps; the pointer is always < CANALES so a single subtraction
    // is enough to wrap, which keeps non-power-of-2 counts correct.
    always_comb begin
        indice  = '0;
        hallado = 1'b0;
        j       = 0;
        for (int i = 0; i < CANALES; i++) begin
            if (modo_i == MODO_RR) begin
                j = int'(puntero) + i;
                if (j >= CANALES) begin
                    j = j - CANALES;
                end
            end else begin
                j = i;
            end
            if (!hallado && valido_i[IW'(j)]) begin
                hallado = 1'b1;
                indice  = IW'(j);
            end
        end
    end

    assign grant_o = habilitado_i & hallado;
    assign canal_o = indice;

    always_comb begin
        listo_o = '0;
        if (grant_o) begin
            listo_o[indice] = 1'b1;
        end
    end

    // The pointer moves past the winner on every transfer, in either mode,
    // so switching to round-robin continues from the last served channel.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            puntero <= '0;
        end else if (grant_o) begin
            if (indice == IW'(CANALES - 1)) begin
                puntero <= '0;
            end else begin
                puntero <= indice + IW'(1);
            end
        end
    end

endmodule : arbitro_rr

// File: rtl/mux_n_a_1_arb.sv
// -----------------------------------------------------------------------------
// mux_n_a_1_arb
// N-to-1 multiplexer with per-channel valid/ready inputs, arbitration
// (fixed priority or round-robin) and a single registered output stage.
//
// Ports
//   clk_i      : clock, rising edge
//   rst_n_i    : asynchronous active-low reset
//   modo_i     : MODO_FIJO (0) fixed priority, MODO_RR (1) round-robin
//   valido_i   : per-channel valid, CANALES bits
//   entradas_i : channel data, channel k at [k*ANCHO +: ANCHO]
//   listo_o    : per-channel accept, one-hot or zero
//   salida_o   : registered selected data
//   valido_o   : salida_o holds an unconsumed word
//   listo_i    : downstream ready
//   canal_o    : index of the channel that produced salida_o
//   estado_o   : current FSM state (0 = VACIO, 1 = LLENO), for observation
//
// Handshake (both sides): a word moves when valid and ready are both 1 at a
// rising clock edge; valid never waits on ready, and the upstream ready
// (listo_o) is derived from request, state and listo_i, never from data.
// -----------------------------------------------------------------------------
module mux_n_a_1_arb
    import mux_pkg::*;
#(
    parameter int ANCHO   = 8,
    parameter int CANALES = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          modo_i,
    input  logic [CANALES-1:0]            valido_i,
    input  logic [CANALES*ANCHO-1:0]      entradas_i,
    output logic [CANALES-1:0]            listo_o,
    output logic [ANCHO-1:0]              salida_o,
    output logic                          valido_o,
    input  logic                          listo_i,
    output logic [$clog2(CANALES)-1:0]    canal_o,
    output logic                          estado_o
);

    localparam int IW = $clog2(CANALES);

    if (CANALES < 2 || CANALES > 16) begin : g_rango
        $error("mux_n_a_1_arb: CANALES must be in 2..16");
    end

    estado_t         estado;
    estado_t         estado_sig;
    logic            habilitado;
    logic            transferencia;
    logic            consumo;
    logic [IW-1:0]   canal_g;
    logic [ANCHO-1:0] datos [CANALES];

    // Unpack the flat data bus so the selection is a plain array index.
    for (genvar k = 0; k < CANALES; k++) begin : g_datos
        assign datos[k] = entradas_i[k*ANCHO +: ANCHO];
    end

    // Arbitrate when the register is empty or is being drained this cycle.
    // Reset forces every accept low so nothing is granted while held.
    assign habilitado = rst_n_i & ((estado == VACIO) | listo_i);
    assign consumo    = (estado == LLENO) & listo_i;

    arbitro_rr #(
        .CANALES (CANALES)
    ) u_arbitro (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .modo_i       (modo_i),
        .habilitado_i (habilitado),
        .valido_i     (valido_i),
        .listo_o      (listo_o),
        .canal_o      (canal_g),
        .grant_o      (transferencia)
    );

    // An accept always refills the register, even when the old word leaves
    // in the same cycle, which is what sustains one word per cycle.
    always_comb begin
        estado_sig = estado;
        if (transferencia) begin
            estado_sig = LLENO;
        end else if (consumo) begin
            estado_sig = VACIO;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            estado <= VACIO;
        end else begin
            estado <= estado_sig;
        end
    end

    // Data and index only move on a transfer; a bare consume leaves
    // salida_o holding its last value.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            salida_o <= '0;
            canal_o  <= '0;
        end else if (transferencia) begin
            salida_o <= datos[canal_g];
            canal_o  <= canal_g;
        end
    end

    assign valido_o = (estado == LLENO);
    assign estado_o = estado;

endmodule : mux_n_a_1_arb

// File: tb/tb_mux_n_a_1_arb.sv
// -----------------------------------------------------------------------------
// tb_mux_n_a_1_arb
// Directed bench: a 4-channel instance for most scenarios and a 3-channel
// instance for the round-robin wrap case. Expected words are pushed when a
// grant is observed; monitors pop on every downstream consume.
// -----------------------------------------------------------------------------
module tb_mux_n_a_1_arb;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // ---------------- 4-channel DUT ----------------
    logic        modo;
    logic [3:0]  valido_i;
    logic [31:0] entradas;
    logic [3:0]  listo_o;
    logic [7:0]  salida;
    logic        valido_o;
    logic        listo_i;
    logic [1:0]  canal;
    logic        estado;

    mux_n_a_1_arb #(.ANCHO(8), .CANALES(4)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .modo_i     (modo),
        .valido_i   (valido_i),
        .entradas_i (entradas),
        .listo_o    (listo_o),
        .salida_o   (salida),
        .valido_o   (valido_o),
        .listo_i    (listo_i),
        .canal_o    (canal),
        .estado_o   (estado)
    );

    // ---------------- 3-channel DUT ----------------
    logic        modo3;
    logic [2:0]  valido3;
    logic [23:0] ent3;
    logic [2:0]  listo3_o;
    logic [7:0]  salida3;
    logic        valido3_o;
    logic        listo3_i;
    logic [1:0]  canal3;
    logic        estado3;

    mux_n_a_1_arb #(.ANCHO(8), .CANALES(3)) dut3 (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .modo_i     (modo3),
        .valido_i   (valido3),
        .entradas_i (ent3),
        .listo_o    (listo3_o),
        .salida_o   (salida3),
        .valido_o   (valido3_o),
        .listo_i    (listo3_i),
        .canal_o    (canal3),
        .estado_o   (estado3)
    );

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [9:0] exp_q[$];
    logic [9:0] exp3_q[$];

    task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] esp);
        n_vec++;
        if (act !== esp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nombre, act, esp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [9:0] e;
        if (rst_n === 1'b1 && valido_o === 1'b1 && listo_i === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb4_underflow: got {%0d,%0h} with nothing expected at %0t", canal, salida, $time);
            end else begin
                e = exp_q.pop_front();
                if ({canal, salida} !== e) begin
                    n_err++;
                    $display("FAIL sb4_word: got {%0d,%0h} expected {%0d,%0h} at %0t",
                             canal, salida, e[9:8], e[7:0], $time);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [9:0] e;
        if (rst_n === 1'b1 && valido3_o === 1'b1 && listo3_i === 1'b1) begin
            n_vec++;
            if (exp3_q.size() == 0) begin
                n_err++;
                $display("FAIL sb3_underflow: got {%0d,%0h} with nothing expected at %0t", canal3, salida3, $time);
            end else begin
                e = exp3_q.pop_front();
                if ({canal3, salida3} !== e) begin
                    n_err++;
                    $display("FAIL sb3_word: got {%0d,%0h} expected {%0d,%0h} at %0t",
                             canal3, salida3, e[9:8], e[7:0], $time);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic siguiente();
        @(posedge clk);
        #1;
    endtask

    task automatic pulso_reset();
        rst_n = 1'b0;
        exp_q.delete();
        exp3_q.delete();
        siguiente();
        rst_n = 1'b1;
    endtask

    task automatic vaciar4();
        valido_i = 4'b0000;
        listo_i  = 1'b1;
        siguiente();
        siguiente();
        @(negedge clk);
        chk("drain4_queue", exp_q.size(), 0);
        chk("drain4_valido", valido_o, 1'b0);
        siguiente();
    endtask

    task automatic vaciar3();
        valido3  = 3'b000;
        listo3_i = 1'b1;
        siguiente();
        siguiente();
        @(negedge clk);
        chk("drain3_queue", exp3_q.size(), 0);
        chk("drain3_valido", valido3_o, 1'b0);
        siguiente();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n    = 1'b0;
        modo     = 1'b0;
        valido_i = 4'b1111;
        entradas = '0;
        listo_i  = 1'b0;
        modo3    = 1'b0;
        valido3  = 3'b000;
        ent3     = '0;
        listo3_i = 1'b0;

        // V1: reset values, accepts held low during reset even with requests
        @(negedge clk);
        chk("v1_rst_listo", listo_o, 4'b0000);
        chk("v1_rst_valido", valido_o, 1'b0);
        chk("v1_rst_salida", salida, 8'h00);
        chk("v1_rst_canal", canal, 2'd0);
        chk("v1_rst_estado", estado, 1'b0);
        siguiente();
        rst_n    = 1'b1;
        valido_i = 4'b0000;
        @(negedge clk);
        chk("v1_idle_listo", listo_o, 4'b0000);
        siguiente();
        @(negedge clk);
        chk("v1_idle_valido", valido_o, 1'b0);
        chk("v1_idle_salida", salida, 8'h00);
        siguiente();

        // V2: fixed priority, ch1 beats ch3 every cycle
        modo     = 1'b0;
        entradas = {8'h33, 8'h22, 8'h11, 8'h00};
        valido_i = 4'b1010;
        listo_i  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("v2_listo", listo_o, 4'b0010);
            exp_q.push_back({2'd1, 8'h11});
            siguiente();
        end
        vaciar4();

        // V3: round-robin from pointer 0, full request
        pulso_reset();
        modo     = 1'b1;
        entradas = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
        valido_i = 4'b1111;
        listo_i  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            int c;
            c = k % 4;
            @(negedge clk);
            chk("v3_listo", listo_o, 4'b0001 << c);
            if (k > 0) chk("v3_valido", valido_o, 1'b1);
            exp_q.push_back({2'(c), 8'(8'hC0 + c)});
            siguiente();
        end
        vaciar4();

        // V4: stall with a held word, then replace in place
        modo     = 1'b0;
        entradas = {8'h00, 8'hA5, 8'h00, 8'h5A};
        valido_i = 4'b0100;
        listo_i  = 1'b0;
        @(negedge clk);
        chk("v4_load_listo", listo_o, 4'b0100);
        exp_q.push_back({2'd2, 8'hA5});
        siguiente();
        valido_i = 4'b0001;
        entradas = {8'h00, 8'hFF, 8'h00, 8'h5A};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("v4_stall_listo", listo_o, 4'b0000);
            chk("v4_stall_salida", salida, 8'hA5);
            chk("v4_stall_canal", canal, 2'd2);
            chk("v4_stall_valido", valido_o, 1'b1);
            siguiente();
        end
        listo_i = 1'b1;
        @(negedge clk);
        chk("v4_accept_listo", listo_o, 4'b0001);
        exp_q.push_back({2'd0, 8'h5A});
        siguiente();
        valido_i = 4'b0000;
        @(negedge clk);
        chk("v4_replaced_salida", salida, 8'h5A);
        chk("v4_replaced_canal", canal, 2'd0);
        siguiente();
        vaciar4();

        // V6: reset mid-stream; pointer (1 here) must return to 0
        modo     = 1'b1;
        entradas = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
        valido_i = 4'b1111;
        listo_i  = 1'b1;
        @(negedge clk);
        chk("v6_pre_listo_a", listo_o, 4'b0010);
        exp_q.push_back({2'd1, 8'hD1});
        siguiente();
        @(negedge clk);
        chk("v6_pre_listo_b", listo_o, 4'b0100);
        exp_q.push_back({2'd2, 8'hD2});
        siguiente();
        #2;
        rst_n = 1'b0;
        #1;
        chk("v6_rst_valido", valido_o, 1'b0);
        chk("v6_rst_salida", salida, 8'h00);
        chk("v6_rst_canal", canal, 2'd0);
        chk("v6_rst_listo", listo_o, 4'b0000);
        exp_q.delete();
        valido_i = 4'b1001;
        @(negedge clk);
        chk("v6_rst_listo_held", listo_o, 4'b0000);
        siguiente();
        rst_n = 1'b1;
        @(negedge clk);
        chk("v6_post_listo_a", listo_o, 4'b0001);
        exp_q.push_back({2'd0, 8'hD0});
        siguiente();
        @(negedge clk);
        chk("v6_post_listo_b", listo_o, 4'b1000);
        exp_q.push_back({2'd3, 8'hD3});
        siguiente();
        vaciar4();

        // V5: 3 channels, move pointer to 2, then wrap to ch0, then ch1
        modo3    = 1'b1;
        ent3     = {8'h62, 8'h61, 8'h60};
        listo3_i = 1'b1;
        valido3  = 3'b010;
        @(negedge clk);
        chk("v5_setup_listo", listo3_o, 3'b010);
        exp3_q.push_back({2'd1, 8'h61});
        siguiente();
        valido3 = 3'b011;
        @(negedge clk);
        chk("v5_wrap_listo", listo3_o, 3'b001);
        exp3_q.push_back({2'd0, 8'h60});
        siguiente();
        @(negedge clk);
        chk("v5_next_listo", listo3_o, 3'b010);
        exp3_q.push_back({2'd1, 8'h61});
        siguiente();
        vaciar3();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_mux_n_a_1_arb
